// File: rtl/hpdl1414_scanner_if.sv
// hpdl1414_scanner_if: character-memory read port, display bus and caret strobe of the scanner.
interface hpdl1414_scanner_if;
    logic       o_read_enable;
    logic [3:0] o_read_address;
    logic [7:0] i_read_data;
    logic       o_caret_strobe;
    logic [1:0] o_disp_addr;
    logic [6:0] o_disp_data;
    logic [3:0] o_disp_wr_n;
    logic       o_frame_done;
    modport master (
        output o_read_enable, o_read_address, o_caret_strobe,
        output o_disp_addr, o_disp_data, o_disp_wr_n, o_frame_done,
        input  i_read_data
    );
    modport slave (
        input  o_read_enable, o_read_address, o_caret_strobe,
        input  o_disp_addr, o_disp_data, o_disp_wr_n, o_frame_done,
        output i_read_data
    );
endinterface

// File: rtl/hpdl1414_scanner.sv
// hpdl1414_scanner: refreshes 16 memory characters into four cascaded HPDL1414s and drives the caret blink strobe.
// Define HPDL1414_CHARSET_FOLD_EN to fold lowercase to uppercase and blank bytes the display cannot show.
module hpdl1414_scanner #(
    parameter int SETUP_CYCLES = 3,
    parameter int WR_CYCLES    = 8,
    parameter int HOLD_CYCLES  = 2,
    parameter int GAP_CYCLES   = 64,
    parameter int BLINK_DIV    = 12500000
) (
    input logic i_clk,
    input logic i_rst,
    hpdl1414_scanner_if.master bus
);
    typedef enum logic [2:0] {IDLE, READ, LATCH, SETUP, WRITE, HOLD, GAP} state_t;
    localparam logic [15:0] SETUP_N = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] WR_N    = 16'(WR_CYCLES - 1);
    localparam logic [15:0] HOLD_N  = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_N   = 16'(GAP_CYCLES - 1);
    localparam logic [23:0] BLINK_N = 24'(BLINK_DIV - 1);
    state_t      state;
    logic [3:0]  idx;
    logic [15:0] cnt;
    logic [23:0] blink_cnt;
    logic [7:0]  rd;
    logic [6:0]  glyph;
    assign rd = bus.i_read_data;
`ifdef HPDL1414_CHARSET_FOLD_EN
    assign glyph = (rd >= 8'h61 && rd <= 8'h7A) ? 7'(rd - 8'h20) :
                   (rd < 8'h20 || rd > 8'h5F)   ? 7'h20 : rd[6:0];
`else
    logic unused_msb;
    assign unused_msb = rd[7];
    assign glyph = rd[6:0];
`endif
    // Phase counter is loaded with length-1 on phase entry and the phase ends when it reaches zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state              <= IDLE;
            idx                <= '0;
            cnt                <= '0;
            bus.o_read_enable  <= 1'b0;
            bus.o_read_address <= '0;
            bus.o_disp_addr    <= '0;
            bus.o_disp_data    <= '0;
            bus.o_disp_wr_n    <= 4'hF;
            bus.o_frame_done   <= 1'b0;
        end else begin
            bus.o_frame_done <= 1'b0;
            cnt              <= cnt - 16'd1;
            case (state)
                IDLE: begin
                    state              <= READ;
                    idx                <= '0;
                    bus.o_read_enable  <= 1'b1;
                    bus.o_read_address <= '0;
                end
                READ: begin
                    state             <= LATCH;
                    bus.o_read_enable <= 1'b0;
                end
                LATCH: begin
                    state           <= SETUP;
                    cnt             <= SETUP_N;
                    bus.o_disp_data <= glyph;
                    bus.o_disp_addr <= ~idx[1:0];
                end
                SETUP: if (cnt == '0) begin
                    state           <= WRITE;
                    cnt             <= WR_N;
                    bus.o_disp_wr_n <= ~(4'b0001 << idx[3:2]);
                end
                WRITE: if (cnt == '0) begin
                    state           <= HOLD;
                    cnt             <= HOLD_N;
                    bus.o_disp_wr_n <= 4'hF;
                end
                HOLD: if (cnt == '0) begin
                    if (idx == 4'd15) begin
                        state            <= GAP;
                        cnt              <= GAP_N;
                        idx              <= '0;
                        bus.o_frame_done <= 1'b1;
                    end else begin
                        state              <= READ;
                        idx                <= idx + 4'd1;
                        bus.o_read_enable  <= 1'b1;
                        bus.o_read_address <= idx + 4'd1;
                    end
                end
                GAP: if (cnt == '0) begin
                    state              <= READ;
                    bus.o_read_enable  <= 1'b1;
                    bus.o_read_address <= idx;
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            blink_cnt          <= '0;
            bus.o_caret_strobe <= 1'b0;
        end else if (blink_cnt == BLINK_N) begin
            blink_cnt          <= '0;
            bus.o_caret_strobe <= ~bus.o_caret_strobe;
        end else begin
            blink_cnt <= blink_cnt + 24'd1;
        end
    end
endmodule
